// File: rtl/system_id_checker.sv
// Reads the system ID and build timestamp words over Avalon-MM and
// compares them against the values this image was built with.
module system_id_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1670414449,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout_err,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_ID = 2'd1,
      RD_TS = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        pass_q, pass_d;
   logic        tmo_q, tmo_d;
   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic        stall;
   logic        tmo_hit;

   assign stall   = avm_waitrequest;
   assign tmo_hit = avm_waitrequest && (cnt_q == TMO_LAST);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         id_q    <= '0;
         ts_q    <= '0;
         pass_q  <= 1'b0;
         tmo_q   <= 1'b0;
         read_q  <= 1'b0;
         addr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         ts_q    <= ts_d;
         pass_q  <= pass_d;
         tmo_q   <= tmo_d;
         read_q  <= read_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = RD_ID;
         end
         RD_ID: begin
            if (!stall)       state_d = RD_TS;
            else if (tmo_hit) state_d = FIN;
         end
         RD_TS: begin
            if (!stall || tmo_hit) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // pass is resolved on the edge entering FIN so it is valid alongside done
   always_comb begin
      cnt_d  = cnt_q;
      id_d   = id_q;
      ts_d   = ts_q;
      pass_d = pass_q;
      tmo_d  = tmo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d  = '0;
               id_d   = '0;
               ts_d   = '0;
               pass_d = 1'b0;
               tmo_d  = 1'b0;
            end
         end
         RD_ID: begin
            if (!stall) begin
               id_d  = avm_readdata;
               cnt_d = '0;
            end else if (tmo_hit) begin
               tmo_d  = 1'b1;
               pass_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RD_TS: begin
            if (!stall) begin
               ts_d   = avm_readdata;
               pass_d = !tmo_q
                        && (id_q == EXPECTED_ID)
                        && (avm_readdata == EXPECTED_TIMESTAMP);
            end else if (tmo_hit) begin
               tmo_d  = 1'b1;
               pass_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: ;
      endcase
   end

   // bus strobes are registered from the next state, so they hold while stalled
   always_comb begin
      read_d = (state_d == RD_ID) || (state_d == RD_TS);
      addr_d = (state_d == RD_TS);
   end

   always_comb begin
      busy            = (state_q != IDLE);
      done            = (state_q == FIN);
      pass            = pass_q;
      timeout_err     = tmo_q;
      id_value        = id_q;
      timestamp_value = ts_q;
      avm_read        = read_q;
      avm_address     = addr_q;
   end

endmodule

// File: tb/tb_system_id_checker.sv
// Scoreboard bench for system_id_checker with a stall-capable Avalon slave.
module tb_system_id_checker;

   localparam logic [31:0] EXP_TS = 32'd1670414449;

   typedef struct packed {
      logic        pass;
      logic        tmo;
      logic [31:0] id;
      logic [31:0] ts;
   } res_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass, timeout_err;
   logic [31:0] id_value, timestamp_value;
   logic        avm_address, avm_read, avm_waitrequest;
   logic [31:0] avm_readdata;

   logic [31:0] mem0 = 32'h0;
   logic [31:0] mem1 = EXP_TS;
   int          stall_n = 0;
   bit          stuck = 1'b0;
   int          wcnt = 0;

   bit          mon_en = 1'b0;
   bit          prev_st = 1'b0;
   logic        prev_addr = 1'b0;
   int          stall_viol = 0;

   int          tests = 0;
   int          errors = 0;
   res_t        expq[$];
   int          latq[$];

   always #5 clock = ~clock;

   system_id_checker #(.TIMEOUT_CYCLES(4)) dut (
      .clock(clock),
      .reset_n(reset_n),
      .start(start),
      .busy(busy),
      .done(done),
      .pass(pass),
      .timeout_err(timeout_err),
      .id_value(id_value),
      .timestamp_value(timestamp_value),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata)
   );

   assign avm_waitrequest = avm_read && (stuck || (wcnt < stall_n));
   assign avm_readdata    = avm_address ? mem1 : mem0;

   always @(posedge clock) begin
      if (!avm_read || !avm_waitrequest) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   always @(negedge clock) begin
      if (mon_en && prev_st && !timeout_err
          && !(avm_read && avm_address == prev_addr))
         stall_viol = stall_viol + 1;
      prev_st   = avm_read && avm_waitrequest;
      prev_addr = avm_address;
   end

   function automatic res_t got_res();
      return {pass, timeout_err, id_value, timestamp_value};
   endfunction

   task automatic go(input bit hold, output int lat, output int rd);
      start = 1'b1;
      lat = 0;
      rd = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         lat++;
         if (!hold) start = 1'b0;
         if (done) break;
         if (avm_read) rd++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      tests++;
      if ({busy, done, pass, timeout_err, avm_read, avm_address,
           id_value, timestamp_value} !== 70'd0) begin
         errors++;
         $display("FAIL reset_state got %h exp 0",
                  {busy, done, pass, timeout_err, avm_read, avm_address,
                   id_value, timestamp_value});
      end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_nostall();
      int lat, rd;
      res_t e, g;
      mem0 = 32'h0; mem1 = EXP_TS; stall_n = 0;
      expq.push_back('{1'b1, 1'b0, 32'h0, EXP_TS});
      latq.push_back(3);
      go(1'b0, lat, rd);
      g = got_res();
      e = expq.pop_front();
      tests++;
      if (g !== e) begin
         errors++;
         $display("FAIL nostall_result got %h exp %h", g, e);
      end
      tests++;
      if (lat !== latq[0]) begin
         errors++;
         $display("FAIL nostall_latency got %0d exp %0d", lat, latq[0]);
      end
      void'(latq.pop_front());
      @(negedge clock);
      tests++;
      if ({busy, done, got_res()} !== {2'b00, e}) begin
         errors++;
         $display("FAIL nostall_after got %h exp %h",
                  {busy, done, got_res()}, {2'b00, e});
      end
   endtask

   task automatic test_bad_id();
      int lat, rd;
      res_t e, g;
      mem0 = 32'h5; mem1 = EXP_TS; stall_n = 0;
      expq.push_back('{1'b0, 1'b0, 32'h5, EXP_TS});
      go(1'b0, lat, rd);
      g = got_res();
      e = expq.pop_front();
      tests++;
      if (g !== e) begin
         errors++;
         $display("FAIL bad_id_result got %h exp %h", g, e);
      end
      tests++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL bad_id_latency got %0d exp 3", lat);
      end
      @(negedge clock);
   endtask

   task automatic test_stall();
      int lat, rd;
      res_t e, g;
      mem0 = 32'h0; mem1 = EXP_TS; stall_n = 3;
      stall_viol = 0;
      mon_en = 1'b1;
      expq.push_back('{1'b1, 1'b0, 32'h0, EXP_TS});
      go(1'b0, lat, rd);
      mon_en = 1'b0;
      g = got_res();
      e = expq.pop_front();
      tests++;
      if (g !== e) begin
         errors++;
         $display("FAIL stall_result got %h exp %h", g, e);
      end
      tests++;
      if (lat !== 9) begin
         errors++;
         $display("FAIL stall_latency got %0d exp 9", lat);
      end
      tests++;
      if (stall_viol !== 0) begin
         errors++;
         $display("FAIL stall_addr_stable got %0d changes exp 0", stall_viol);
      end
      stall_n = 0;
      @(negedge clock);
   endtask

   task automatic test_timeout();
      int lat, rd;
      res_t e, g;
      mem0 = 32'h0; mem1 = EXP_TS; stuck = 1'b1;
      expq.push_back('{1'b0, 1'b1, 32'h0, 32'h0});
      go(1'b0, lat, rd);
      g = got_res();
      e = expq.pop_front();
      tests++;
      if (g !== e) begin
         errors++;
         $display("FAIL timeout_result got %h exp %h", g, e);
      end
      tests++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL timeout_latency got %0d exp 5", lat);
      end
      tests++;
      if (rd !== 4) begin
         errors++;
         $display("FAIL timeout_read_cycles got %0d exp 4", rd);
      end
      tests++;
      if (avm_read !== 1'b0) begin
         errors++;
         $display("FAIL timeout_read_drop got %b exp 0", avm_read);
      end
      stuck = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid();
      int lat, rd;
      bit seen;
      res_t e, g;
      mem0 = 32'h0; mem1 = EXP_TS; stall_n = 3;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (avm_address) break;
         @(negedge clock);
      end
      reset_n = 1'b0;
      @(negedge clock);
      tests++;
      if ({busy, done, pass, timeout_err, avm_read, avm_address,
           id_value, timestamp_value} !== 70'd0) begin
         errors++;
         $display("FAIL reset_mid_abort got %h exp 0",
                  {busy, done, pass, timeout_err, avm_read, avm_address,
                   id_value, timestamp_value});
      end
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clock);
         if (done) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_no_done got %b exp 0", seen);
      end
      stall_n = 0;
      expq.push_back('{1'b1, 1'b0, 32'h0, EXP_TS});
      go(1'b0, lat, rd);
      g = got_res();
      e = expq.pop_front();
      tests++;
      if (g !== e) begin
         errors++;
         $display("FAIL reset_mid_rerun got %h exp %h", g, e);
      end
      tests++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL reset_mid_rerun_latency got %0d exp 3", lat);
      end
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      int lat, rd, gap;
      res_t e, g;
      mem0 = 32'h0; mem1 = EXP_TS; stall_n = 0;
      expq.push_back('{1'b1, 1'b0, 32'h0, EXP_TS});
      expq.push_back('{1'b0, 1'b0, 32'h7, EXP_TS});
      go(1'b1, lat, rd);
      g = got_res();
      e = expq.pop_front();
      tests++;
      if (g !== e) begin
         errors++;
         $display("FAIL b2b_first got %h exp %h", g, e);
      end
      mem0 = 32'h7;
      @(negedge clock);
      tests++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_gap got busy=%b exp 0", busy);
      end
      @(negedge clock);
      tests++;
      if ({busy, avm_read, avm_address} !== 3'b110) begin
         errors++;
         $display("FAIL b2b_restart got %b exp 110",
                  {busy, avm_read, avm_address});
      end
      gap = 2;
      for (int i = 0; i < 30; i++) begin
         if (done) break;
         @(negedge clock);
         gap++;
      end
      start = 1'b0;
      g = got_res();
      e = expq.pop_front();
      tests++;
      if (g !== e || gap !== 4) begin
         errors++;
         $display("FAIL b2b_second got %h gap %0d exp %h gap 4", g, gap, e);
      end
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_nostall();
      test_bad_id();
      test_stall();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
